// File: rtl/lt16_vector_driver_if.sv
// Control/status and DUT-operand bundle between the lt16 vector driver and its surroundings.
// master is the driver side; slave is the wrapper/bench side.
interface lt16_vector_driver_if #(
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned CNT_W    = 16
);
  logic                start;
  logic [CNT_W-1:0]    num_vectors;
  logic                dut_result;
  logic [BITWIDTH-1:0] a;
  logic [BITWIDTH-1:0] b;
  logic                busy;
  logic                done;
  logic                pass;
  logic [CNT_W-1:0]    err_count;
  logic [CNT_W-1:0]    first_err_idx;
  logic [BITWIDTH-1:0] first_err_a;
  logic [BITWIDTH-1:0] first_err_b;

  modport master (
    input  start, num_vectors, dut_result,
    output a, b, busy, done, pass, err_count, first_err_idx, first_err_a, first_err_b
  );

  modport slave (
    output start, num_vectors, dut_result,
    input  a, b, busy, done, pass, err_count, first_err_idx, first_err_a, first_err_b
  );
endinterface

// File: rtl/lt16_vector_driver.sv
// Self-checking LFSR stimulus driver for the flopped 16-bit less-than DUT.
// Define LT16_DRIVER_ERR_LOG_EN to build the first-mismatch capture registers.
module lt16_vector_driver #(
  parameter int unsigned         BITWIDTH    = 16,
  parameter int unsigned         DUT_LATENCY = 4,
  parameter logic [BITWIDTH-1:0] SEED_A      = 16'hACE1,
  parameter logic [BITWIDTH-1:0] SEED_B      = 16'h1D2B,
  parameter int unsigned         CNT_W       = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  lt16_vector_driver_if.master bus
);

  localparam int unsigned DL = DUT_LATENCY + 1;
  localparam logic [BITWIDTH-1:0] LfsrMask = 16'hB400;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  function automatic logic [BITWIDTH-1:0] lfsr_step(input logic [BITWIDTH-1:0] v);
    return {1'b0, v[BITWIDTH-1:1]} ^ (v[0] ? LfsrMask : '0);
  endfunction

  // Fold of the 32-bit square: low half XOR high half.
  function automatic logic [BITWIDTH-1:0] fold_sq(input logic [BITWIDTH-1:0] x);
    logic [2*BITWIDTH-1:0] sq;
    sq = {{BITWIDTH{1'b0}}, x} * {{BITWIDTH{1'b0}}, x};
    return sq[BITWIDTH-1:0] ^ sq[2*BITWIDTH-1:BITWIDTH];
  endfunction

  state_e              state_q;
  logic [BITWIDTH-1:0] a_q, b_q;
  logic [BITWIDTH-1:0] lfsr_a_q, lfsr_b_q;
  logic [CNT_W-1:0]    vec_cnt_q, num_q, err_q;
  logic [DL-1:0]       dl_valid_q, dl_exp_q;
  logic                busy_q, done_q;

  logic [BITWIDTH-1:0] issue_a, issue_b;
  logic                exp_new, check_now, mismatch, last_check, idle_like;

  always_comb begin
    idle_like  = (state_q == StIdle) || (state_q == StDone);
    issue_a    = idle_like ? SEED_A : lfsr_a_q;
    issue_b    = idle_like ? SEED_B : lfsr_b_q;
    exp_new    = fold_sq(issue_a) < fold_sq(issue_b);
    check_now  = dl_valid_q[DL-1];
    mismatch   = check_now && (bus.dut_result != dl_exp_q[DL-1]);
    // The oldest valid entry with nothing valid behind it is the run's last vector.
    last_check = check_now && (dl_valid_q[DL-2:0] == '0);
  end

`ifdef LT16_DRIVER_ERR_LOG_EN
  // Trailing LFSR pair reproduces the operands of the vector currently being checked.
  logic [CNT_W-1:0]    chk_idx_q, first_idx_q;
  logic [BITWIDTH-1:0] chk_a_q, chk_b_q, first_a_q, first_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_idx_q   <= '0;
      chk_a_q     <= SEED_A;
      chk_b_q     <= SEED_B;
      first_idx_q <= '0;
      first_a_q   <= '0;
      first_b_q   <= '0;
    end else if (idle_like && bus.start) begin
      chk_idx_q   <= '0;
      chk_a_q     <= SEED_A;
      chk_b_q     <= SEED_B;
      first_idx_q <= '0;
      first_a_q   <= '0;
      first_b_q   <= '0;
    end else if (check_now) begin
      chk_idx_q <= chk_idx_q + 1'b1;
      chk_a_q   <= lfsr_step(chk_a_q);
      chk_b_q   <= lfsr_step(chk_b_q);
      if (mismatch && err_q == '0) begin
        first_idx_q <= chk_idx_q;
        first_a_q   <= chk_a_q;
        first_b_q   <= chk_b_q;
      end
    end
  end

  assign bus.first_err_idx = first_idx_q;
  assign bus.first_err_a   = first_a_q;
  assign bus.first_err_b   = first_b_q;
`else
  assign bus.first_err_idx = '0;
  assign bus.first_err_a   = '0;
  assign bus.first_err_b   = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      lfsr_a_q   <= SEED_A;
      lfsr_b_q   <= SEED_B;
      vec_cnt_q  <= '0;
      num_q      <= '0;
      err_q      <= '0;
      dl_valid_q <= '0;
      dl_exp_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      dl_valid_q <= {dl_valid_q[DL-2:0], 1'b0};
      dl_exp_q   <= {dl_exp_q[DL-2:0], 1'b0};
      if (mismatch && err_q != '1) begin
        err_q <= err_q + 1'b1;
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            err_q <= '0;
            if (bus.num_vectors != '0) begin
              a_q        <= SEED_A;
              b_q        <= SEED_B;
              lfsr_a_q   <= lfsr_step(SEED_A);
              lfsr_b_q   <= lfsr_step(SEED_B);
              dl_valid_q <= {{(DL-1){1'b0}}, 1'b1};
              dl_exp_q   <= {{(DL-1){1'b0}}, exp_new};
              vec_cnt_q  <= {{(CNT_W-1){1'b0}}, 1'b1};
              num_q      <= bus.num_vectors;
              state_q    <= (bus.num_vectors == {{(CNT_W-1){1'b0}}, 1'b1}) ? StDrain : StRun;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          a_q        <= lfsr_a_q;
          b_q        <= lfsr_b_q;
          lfsr_a_q   <= lfsr_step(lfsr_a_q);
          lfsr_b_q   <= lfsr_step(lfsr_b_q);
          dl_valid_q <= {dl_valid_q[DL-2:0], 1'b1};
          dl_exp_q   <= {dl_exp_q[DL-2:0], exp_new};
          vec_cnt_q  <= vec_cnt_q + 1'b1;
          if (vec_cnt_q == num_q - 1'b1) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (last_check) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_count = err_q;
  assign bus.pass      = done_q && (err_q == '0);

endmodule
